// File: rtl/common_bus_pkg.sv
// Shared constants for the basic-computer common-bus controller.
package common_bus_pkg;
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NSRC  = 8;
  localparam int DEF_CNT_W = 8;

  localparam int SRC_AR  = 1;
  localparam int SRC_PC  = 2;
  localparam int SRC_DR  = 3;
  localparam int SRC_AC  = 4;
  localparam int SRC_IR  = 5;
  localparam int SRC_TR  = 6;
  localparam int SRC_MEM = 7;
endpackage

// File: rtl/bus_grant_arb.sv
// Combinational grant selection: fixed (highest index) or round-robin after ptr.
module bus_grant_arb #(
  parameter int NSRC  = 8,
  parameter int SEL_W = $clog2(NSRC)
) (
  input  logic [NSRC-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             mode,
  output logic [SEL_W-1:0] grant,
  output logic             any,
  output logic             multi
);
  int   idx;
  logic found;

  assign any   = |req;
  assign multi = |(req & (req - NSRC'(1)));

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    if (mode) begin
      // Search starts just past the last winner and wraps.
      for (int k = 1; k <= NSRC; k++) begin
        idx = (int'(ptr) + k) % NSRC;
        if (!found && req[idx]) begin
          grant = SEL_W'(idx);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (req[i]) grant = SEL_W'(i);
      end
    end
  end
endmodule

// File: rtl/common_bus_ctrl.sv
// Registered common-bus controller: one grant per cycle, conflict flag and counter.
module common_bus_ctrl
  import common_bus_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NSRC  = DEF_NSRC,
  parameter int SEL_W = $clog2(NSRC),
  parameter int MODE  = MODE_FIXED,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NSRC-1:0]       src_req,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic                  bus_hold,
  input  logic                  conflict_clr,
  output logic [SEL_W-1:0]      bus_sel,
  output logic [WIDTH-1:0]      bus_data,
  output logic                  bus_valid,
  output logic                  conflict,
  output logic [CNT_W-1:0]      conflict_cnt
);
  logic [SEL_W-1:0] grant;
  logic             any;
  logic             multi;
  logic [SEL_W-1:0] ptr_p0;
  logic [SEL_W-1:0] sel_p0;
  logic [WIDTH-1:0] data_p0;
  logic             vld_p0;
  logic             flag_p0;
  logic [CNT_W-1:0] cnt_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  bus_grant_arb #(.NSRC(NSRC), .SEL_W(SEL_W)) u_arb (
    .req   (src_req),
    .ptr   (ptr_p0),
    .mode  (MODE == MODE_RR),
    .grant (grant),
    .any   (any),
    .multi (multi)
  );

  // Stage p0: grant register, rotating pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_p0  <= SEL_W'(NSRC - 1);
      sel_p0  <= '0;
      data_p0 <= '0;
      vld_p0  <= 1'b0;
    end else if (!bus_hold) begin
      vld_p0 <= any;
      if (any) begin
        ptr_p0  <= grant;
        sel_p0  <= grant;
        data_p0 <= src_data[int'(grant)*WIDTH +: WIDTH];
      end
    end
  end

  // Stage p0: conflict tracking; a conflict in the clearing cycle restarts at 1
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_p0 <= 1'b0;
      cnt_p0  <= '0;
    end else if (!bus_hold && multi) begin
      flag_p0 <= 1'b1;
      cnt_p0  <= conflict_clr ? CNT_W'(1) : sat_inc(cnt_p0);
    end else if (conflict_clr) begin
      flag_p0 <= 1'b0;
      cnt_p0  <= '0;
    end
  end

  assign bus_sel      = sel_p0;
  assign bus_data     = data_p0;
  assign bus_valid    = vld_p0;
  assign conflict     = flag_p0;
  assign conflict_cnt = cnt_p0;
endmodule

// File: tb/tb_common_bus_ctrl.sv
// Directed bench: a fixed-priority and a round-robin instance share one stimulus.
module tb_common_bus_ctrl;
  import common_bus_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   src_req = '0;
  logic [127:0] src_data = '0;
  logic         bus_hold = 1'b0;
  logic         conflict_clr = 1'b0;

  logic [2:0]  sel0, sel1;
  logic [15:0] data0, data1;
  logic        vld0, vld1, cf0, cf1;
  logic [7:0]  cnt0, cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  common_bus_ctrl #(.WIDTH(16), .NSRC(8), .MODE(MODE_FIXED), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .src_req(src_req), .src_data(src_data),
    .bus_hold(bus_hold), .conflict_clr(conflict_clr),
    .bus_sel(sel0), .bus_data(data0), .bus_valid(vld0),
    .conflict(cf0), .conflict_cnt(cnt0)
  );

  common_bus_ctrl #(.WIDTH(16), .NSRC(8), .MODE(MODE_RR), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .src_req(src_req), .src_data(src_data),
    .bus_hold(bus_hold), .conflict_clr(conflict_clr),
    .bus_sel(sel1), .bus_data(data1), .bus_valid(vld1),
    .conflict(cf1), .conflict_cnt(cnt1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [15:0] v);
    src_data[i*16 +: 16] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_req = '0;
    bus_hold = 1'b0;
    conflict_clr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    src_req = 8'b0000_0100;
    rst = 1'b1;
    step();
    step();
    checks++; if (sel0 !== 3'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel0); end
    checks++; if (data0 !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=0000", data0); end
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", vld0); end
    checks++; if (cf0 !== 1'b0) begin errors++; $display("FAIL reset_conflict got=%b exp=0", cf0); end
    checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt0); end
    checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL reset_valid_rr got=%b exp=0", vld1); end
    src_req = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_word(SRC_PC, 16'h0123);
    src_req = 8'b0000_0100;
    step();
    checks++; if (sel0 !== 3'd2) begin errors++; $display("FAIL single_sel got=%0d exp=2", sel0); end
    checks++; if (data0 !== 16'h0123) begin errors++; $display("FAIL single_data got=%h exp=0123", data0); end
    checks++; if (vld0 !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", vld0); end
    checks++; if (cf0 !== 1'b0) begin errors++; $display("FAIL single_conflict got=%b exp=0", cf0); end
    checks++; if (sel1 !== 3'd2) begin errors++; $display("FAIL single_sel_rr got=%0d exp=2", sel1); end
  endtask

  task automatic test_fixed_conflict();
    set_word(SRC_MEM, 16'hBEEF);
    set_word(SRC_AC, 16'h1111);
    src_req = 8'b1001_0000;
    step();
    checks++; if (sel0 !== 3'd7) begin errors++; $display("FAIL fixed_sel got=%0d exp=7", sel0); end
    checks++; if (data0 !== 16'hBEEF) begin errors++; $display("FAIL fixed_data got=%h exp=beef", data0); end
    checks++; if (cf0 !== 1'b1) begin errors++; $display("FAIL fixed_conflict got=%b exp=1", cf0); end
    checks++; if (cnt0 !== 8'd1) begin errors++; $display("FAIL fixed_cnt got=%0d exp=1", cnt0); end
    // ptr=2 in the round-robin instance, so AC (4) comes before M[AR] (7)
    checks++; if (sel1 !== 3'd4) begin errors++; $display("FAIL rr_after_pc_sel got=%0d exp=4", sel1); end
    checks++; if (data1 !== 16'h1111) begin errors++; $display("FAIL rr_after_pc_data got=%h exp=1111", data1); end
    for (int i = 0; i < 253; i++) step();
    checks++; if (cnt0 !== 8'd254) begin errors++; $display("FAIL cnt_254 got=%0d exp=254", cnt0); end
    step();
    checks++; if (cnt0 !== 8'd255) begin errors++; $display("FAIL cnt_255 got=%0d exp=255", cnt0); end
    for (int i = 0; i < 45; i++) step();
    checks++; if (cnt0 !== 8'd255) begin errors++; $display("FAIL cnt_saturate got=%0d exp=255", cnt0); end
  endtask

  task automatic test_clear_idle();
    src_req = '0;
    conflict_clr = 1'b1;
    step();
    checks++; if (cf0 !== 1'b0) begin errors++; $display("FAIL clr_flag got=%b exp=0", cf0); end
    checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL clr_cnt got=%0d exp=0", cnt0); end
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", vld0); end
    checks++; if (data0 !== 16'hBEEF) begin errors++; $display("FAIL idle_data_hold got=%h exp=beef", data0); end
    checks++; if (sel0 !== 3'd7) begin errors++; $display("FAIL idle_sel_hold got=%0d exp=7", sel0); end
    step();
    checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL clr_no_conflict_cnt got=%0d exp=0", cnt0); end
    src_req = 8'b1001_0000;
    step();
    checks++; if (cf0 !== 1'b1) begin errors++; $display("FAIL clr_with_conflict_flag got=%b exp=1", cf0); end
    checks++; if (cnt0 !== 8'd1) begin errors++; $display("FAIL clr_with_conflict_cnt got=%0d exp=1", cnt0); end
    conflict_clr = 1'b0;
    step();
    checks++; if (cnt0 !== 8'd2) begin errors++; $display("FAIL post_clr_cnt got=%0d exp=2", cnt0); end
  endtask

  task automatic test_rr_fairness();
    logic [2:0] exp_seq [4];
    logic [2:0] wrap_seq [3];
    exp_seq = '{3'd1, 3'd3, 3'd1, 3'd3};
    wrap_seq = '{3'd0, 3'd7, 3'd0};
    do_reset();
    src_req = 8'b0000_1010;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (sel1 !== exp_seq[i]) begin errors++; $display("FAIL rr_seq[%0d] got=%0d exp=%0d", i, sel1, exp_seq[i]); end
    end
    checks++; if (sel0 !== 3'd3) begin errors++; $display("FAIL fixed_dr_ar got=%0d exp=3", sel0); end
    checks++; if (cnt1 !== 8'd4) begin errors++; $display("FAIL rr_cnt got=%0d exp=4", cnt1); end
    do_reset();
    src_req = 8'b1000_0001;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (sel1 !== wrap_seq[i]) begin errors++; $display("FAIL rr_wrap[%0d] got=%0d exp=%0d", i, sel1, wrap_seq[i]); end
    end
  endtask

  task automatic test_hold();
    do_reset();
    set_word(SRC_PC, 16'h0123);
    set_word(SRC_AC, 16'h4444);
    src_req = 8'b0000_0100;
    step();
    bus_hold = 1'b1;
    src_req = 8'b0001_1000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (sel0 !== 3'd2 || data0 !== 16'h0123 || vld0 !== 1'b1) begin
        errors++; $display("FAIL hold_frozen[%0d] got=%0d/%h/%b exp=2/0123/1", i, sel0, data0, vld0);
      end
      checks++; if (cnt0 !== 8'd0 || cf0 !== 1'b0) begin
        errors++; $display("FAIL hold_no_conflict[%0d] got=%0d/%b exp=0/0", i, cnt0, cf0);
      end
    end
    src_req = 8'b0000_0000;
    step();
    checks++; if (vld0 !== 1'b1) begin errors++; $display("FAIL hold_idle_valid got=%b exp=1", vld0); end
    bus_hold = 1'b0;
    src_req = 8'b0001_0000;
    step();
    checks++; if (sel0 !== 3'd4 || data0 !== 16'h4444) begin errors++; $display("FAIL release_ac got=%0d/%h exp=4/4444", sel0, data0); end
    checks++; if (sel1 !== 3'd4) begin errors++; $display("FAIL release_ac_rr got=%0d exp=4", sel1); end
    src_req = '0;
    set_word(SRC_AC, 16'h5555);
    step();
    checks++; if (data0 !== 16'h4444 || vld0 !== 1'b0) begin errors++; $display("FAIL sample_once got=%h/%b exp=4444/0", data0, vld0); end
  endtask

  task automatic test_reset_mid();
    src_req = 8'b0000_0100;
    step();
    rst = 1'b1;
    src_req = 8'b1001_0000;
    step();
    checks++; if (sel0 !== 3'd0 || data0 !== 16'h0 || vld0 !== 1'b0 || cf0 !== 1'b0 || cnt0 !== 8'd0) begin
      errors++; $display("FAIL mid_reset got=%0d/%h/%b/%b/%0d exp=0/0000/0/0/0", sel0, data0, vld0, cf0, cnt0);
    end
    rst = 1'b0;
    src_req = 8'b0000_0100;
    step();
    checks++; if (sel0 !== 3'd2 || data0 !== 16'h0123 || vld0 !== 1'b1) begin
      errors++; $display("FAIL post_reset_grant got=%0d/%h/%b exp=2/0123/1", sel0, data0, vld0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fixed_conflict();
    test_clear_idle();
    test_rr_fairness();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/common_bus_ctrl.md
# common_bus_ctrl

Parametrised, registered common-bus controller for the basic computer datapath. It takes the per-source request vector produced by control decode (AR, PC, DR, AC, IR, TR, M[AR], …) and grants exactly one source. It drives the encoded select and the selected word onto the bus one cycle later. It resolves illegal multi-source requests by fixed or round-robin arbitration, and records them in a sticky conflict flag and a saturating counter.

## Interface
Parameters:
- WIDTH, 16, bus word width in bits
- NSRC, 8, number of bus sources (≥2)
- SEL_W, $clog2(NSRC), encoded select width (derived, not overridden)
- MODE, 0, arbitration mode: 0 = fixed priority (highest index wins), 1 = round-robin
- CNT_W, 8, conflict counter width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- src_req  in  NSRC  request per source; one-hot intended
- src_data  in  NSRC*WIDTH  source words, source i at bits [i*WIDTH +: WIDTH]
- bus_hold  in  1  wait state; freezes bus and arbitration state
- conflict_clr  in  1  clears conflict flag and counter
- bus_sel  out  SEL_W  encoded index of granted source (S2..S0 equivalent)
- bus_data  out  WIDTH  registered bus word
- bus_valid  out  1  a source was granted last cycle
- conflict  out  1  sticky: ≥2 requests seen since last clear/reset
- conflict_cnt  out  CNT_W  number of conflict cycles, saturating

## Operation
- Each cycle with bus_hold=0:
  - popcount(src_req)=0: bus_valid←0; bus_sel and bus_data hold; pointer holds.
  - Exactly one request: grant that index g. bus_sel←g, bus_data←src_data[g], bus_valid←1.
  - ≥2 requests: grant per MODE, load as above. conflict←1; conflict_cnt←min(cnt+1, 2^CNT_W−1).
- MODE 0: grant is the highest set index. M[AR] at index 7 wins, matching memory-read precedence.
- MODE 1: rotating pointer ptr. Search from ptr+1 upward, wrapping modulo NSRC; the first set bit is granted, then ptr←g. Single requests also update ptr.
- With bus_hold=1: bus_sel, bus_data, bus_valid and ptr hold. Requests are ignored and do not count as conflicts.
- conflict_clr=1 (independent of hold): conflict←0, cnt←0.
  - Exception: a conflict counted in the same cycle wins, giving conflict←1, cnt←1.
- Counter saturates at all-ones; it never wraps.

## Timing
- Latency: request at edge N → bus_sel/bus_data/bus_valid valid after edge N+1. No combinational path from inputs to outputs.
- Full throughput: a new grant every non-hold cycle.
- Reset values:
  - bus_sel=0, bus_data=0, bus_valid=0
  - conflict=0, conflict_cnt=0
  - ptr=NSRC−1, so the first round-robin search starts at index 0
- rst has priority over bus_hold and conflict_clr.
- Reset asserted mid-stream discards the pending grant; the first post-reset grant appears one cycle after the first request with rst=0.
- src_data is sampled only at the granting edge; later changes do not affect bus_data.

## Structure
- Package common_bus_pkg:
  - MODE_FIXED=0, MODE_RR=1
  - default WIDTH/NSRC/CNT_W constants
  - source index constants SRC_AR=1, SRC_PC=2, SRC_DR=3, SRC_AC=4, SRC_IR=5, SRC_TR=6, SRC_MEM=7
- Sub-module bus_grant_arb:
  - purely combinational
  - inputs: req, ptr, mode
  - outputs: grant index, any, multi
- The top module holds all registers: bus regs, ptr, conflict flag, counter.

## Test plan
- Reset, then single requests: src_req=8'b0000_0100 with PC=16'h0123 → next cycle bus_sel=2, bus_data=16'h0123, bus_valid=1, conflict=0.
- MODE 0 conflict: req=8'b1001_0000 (AC and M[AR]), mem word 16'hBEEF → bus_sel=7, bus_data=16'hBEEF, conflict=1, conflict_cnt=1. Repeat 300 cycles with CNT_W=8 → cnt holds at 255.
- MODE 1 fairness: req=8'b0000_1010 held for 4 cycles after reset → bus_sel sequence 1,3,1,3.
- Hold: grant PC, then bus_hold=1 while req switches to AC with conflicts present → outputs frozen, cnt unchanged; release → AC granted next cycle.
- Clear: conflict_clr with no conflict → flag 0, cnt 0. conflict_clr together with a conflicting request → flag 1, cnt 1.
- Idle and reset: req=0 after a grant → bus_valid=0 with bus_data held. rst mid-stream → all outputs 0 on the next cycle.
